can_reg_write_arb: RTL
======================

CAN_REG_WRITE_ARB -- requirements
Module: can_reg_write_arb

Interface
REQ-001 SHALL have parameter AW, default 8, meaning register address width.
REQ-002 SHALL have parameter DW, default 8, meaning register data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive cycles a pending host request loses before it is forced to win.
REQ-004 SHALL have parameters PROT_LO, default 0, and PROT_HI, default 7, meaning the inclusive address range writable only in reset mode.
REQ-005 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port reset_mode, input, 1 bit: controller is in reset mode.
REQ-008 SHALL have ports host_req (input, 1), host_addr (input, AW), host_wdata (input, DW), host_ack (output, 1) and host_err (output, 1): host write channel.
REQ-009 SHALL have ports core_req (input, 1), core_addr (input, AW), core_wdata (input, DW) and core_gnt (output, 1): core status-update channel.
REQ-010 SHALL have ports reg_we (output, 1), reg_addr (output, AW) and reg_wdata (output, DW): a single write port driving the register-bank write enables.

Function
REQ-011 SHALL hold the request levels host_req and core_req, with address and data stable, until host_ack or core_gnt respectively is seen; deasserting a request before then is illegal.
REQ-012 SHALL use FSM states IDLE, WR_HOST, WR_CORE and DONE.
REQ-013 SHALL make the following transitions: IDLE to WR_* on any request; WR_* to DONE after exactly 1 cycle; DONE to IDLE after 1 cycle (a mandatory turnaround, so requests are not re-sampled before they drop).
REQ-014 SHALL, in WR_HOST or WR_CORE, register reg_we=1 together with the captured addr/data, and pulse host_ack or core_gnt for the same single cycle.
REQ-015 SHALL give a latency of 1 cycle from request sampled in IDLE to reg_we/ack; back-to-back throughput is 1 write per 3 cycles.
REQ-016 SHALL grant core over host when both are requested in IDLE (fixed priority, macro absent).
REQ-017 SHALL maintain a starve counter (width clog2(STARVE_LIMIT+1)): increment it when host_req is pending and core wins; clear it on a host grant or when host_req is low; saturate it at STARVE_LIMIT.
REQ-018 SHALL grant host in IDLE when starve counter == STARVE_LIMIT, even if core_req=1.
REQ-019 SHALL, for a host write with PROT_LO <= host_addr <= PROT_HI while reset_mode=0, suppress reg_we, pulse host_ack and host_err together, and otherwise follow the normal FSM path.
REQ-020 SHALL exempt core writes from protection.
REQ-021 SHALL sample reset_mode in IDLE at the grant decision; a change during WR_HOST has no effect on the write in flight.
REQ-022 SHALL keep reg_addr/reg_wdata holding their last values when reg_we=0.

Reset
REQ-023 SHALL, on rst low, immediately set FSM=IDLE, starve counter=0, reg_we=0, reg_addr=0, reg_wdata=0, host_ack=0, host_err=0 and core_gnt=0.
REQ-024 SHALL abort a write in flight if reset asserts mid-operation; no reg_we or ack pulse is issued after reset release for that request, and the requester re-arbitrates.

Configuration
REQ-025 SHALL, when macro CAN_ARB_ROUND_ROBIN_EN is defined, replace REQ-016/017/018: on simultaneous requests, grant the requester not granted last; a last-granted flag resets to "host", so core wins the first tie; the starve counter is not implemented.
REQ-026 SHALL, when CAN_ARB_ROUND_ROBIN_EN is not defined, apply fixed core priority with the starvation guard.

Structure
REQ-027 SHALL define the FSM state enum typedef, the grant-source enum (GNT_HOST, GNT_CORE) and the default AW/DW constants in shared package can_pkg.
REQ-028 SHALL place the protection-range check in sub-module can_addr_prot_chk (combinational compare of addr against PROT_LO/PROT_HI plus reset_mode, outputs allow); the rest of the logic stays flat.

Verification
REQ-029 SHALL cover a host-only write: host_req=1, addr=0x0A, data=0x5C, reset_mode=0 -> next cycle reg_we=1, reg_addr=0x0A, reg_wdata=0x5C, host_ack=1, host_err=0; IDLE again 2 cycles later.
REQ-030 SHALL cover a simultaneous request: host 0x0B/0x11 and core 0x0C/0x22 -> core written first; host written 3 cycles later.
REQ-031 SHALL cover starvation: core_req held high continuously with host pending, STARVE_LIMIT=4 -> core wins 4 grants, the 5th grant goes to host.
REQ-032 SHALL cover protection: host addr=0x03, reset_mode=0 -> reg_we stays 0, host_ack=host_err=1 for 1 cycle; the same write with reset_mode=1 -> reg_we=1, host_err=0.
REQ-033 SHALL cover reset mid-write: rst low in WR_HOST -> all outputs 0 immediately, no ack pulse after release until re-arbitration.
REQ-034 SHALL cover round robin under CAN_ARB_ROUND_ROBIN_EN: both requesters held high -> grants alternate core, host, core, host.

Source files
------------

// File: rtl/can_pkg.sv
// Shared types and default widths for the CAN register write arbiter.
package can_pkg;

    localparam int CAN_AW = 8;
    localparam int CAN_DW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_HOST = 2'd1,
        WR_CORE = 2'd2,
        DONE    = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_HOST = 1'b0,
        GNT_CORE = 1'b1
    } gnt_src_e;

endpackage

// File: rtl/can_addr_prot_chk.sv
// Write-protection check: addresses in [PROT_LO, PROT_HI] are writable only in reset mode.
module can_addr_prot_chk #(
    parameter int AW      = 8,
    parameter int PROT_LO = 0,
    parameter int PROT_HI = 7
) (
    input  logic [AW-1:0] addr,
    input  logic          reset_mode,
    output logic          allow
);

    // Compare as signed 32-bit so a zero lower bound does not degenerate into a constant test.
    logic signed [31:0] addr_s;
    logic               in_range;

    assign addr_s   = signed'(32'(addr));
    assign in_range = (addr_s >= PROT_LO) && (addr_s <= PROT_HI);
    assign allow    = reset_mode || !in_range;

endmodule

// File: rtl/can_reg_write_arb.sv
// Arbitrates host and core writes onto a single register-bank write port.
// Optional macro CAN_ARB_ROUND_ROBIN_EN swaps fixed core priority for round robin.
module can_reg_write_arb
    import can_pkg::*;
#(
    parameter int AW           = CAN_AW,
    parameter int DW           = CAN_DW,
    parameter int STARVE_LIMIT = 4,
    parameter int PROT_LO      = 0,
    parameter int PROT_HI      = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          reset_mode,
    input  logic          host_req,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic          host_err,
    input  logic          core_req,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          reg_we,
    output logic [AW-1:0] reg_addr,
    output logic [DW-1:0] reg_wdata
);

    arb_state_e    state_q, state_d;
    logic          reg_we_q, reg_we_d;
    logic [AW-1:0] reg_addr_q, reg_addr_d;
    logic [DW-1:0] reg_wdata_q, reg_wdata_d;
    logic          host_ack_q, host_ack_d;
    logic          host_err_q, host_err_d;
    logic          core_gnt_q, core_gnt_d;
    logic          host_allow;
    logic          host_win;

    can_addr_prot_chk #(
        .AW      (AW),
        .PROT_LO (PROT_LO),
        .PROT_HI (PROT_HI)
    ) u_prot_chk (
        .addr       (host_addr),
        .reset_mode (reset_mode),
        .allow      (host_allow)
    );

`ifdef CAN_ARB_ROUND_ROBIN_EN
    gnt_src_e last_gnt_q, last_gnt_d;

    assign host_win = host_req && (!core_req || (last_gnt_q == GNT_CORE));

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (state_q == IDLE) begin
            if (host_win) begin
                last_gnt_d = GNT_HOST;
            end else if (core_req) begin
                last_gnt_d = GNT_CORE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt_q <= GNT_HOST;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`else
    localparam int             SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_q, starve_d;

    assign host_win = host_req && (!core_req || (starve_q == STARVE_MAX));

    // Counts only grant decisions the host lost; any idle-host cycle wipes the history.
    always_comb begin
        starve_d = starve_q;
        if (!host_req) begin
            starve_d = '0;
        end else if (state_q == IDLE) begin
            if (host_win) begin
                starve_d = '0;
            end else if (core_req && (starve_q != STARVE_MAX)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    // Outputs are registered so they line up with the WR_* state; DONE gives requesters time to drop.
    always_comb begin
        state_d     = state_q;
        reg_we_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        host_ack_d  = 1'b0;
        host_err_d  = 1'b0;
        core_gnt_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (host_win) begin
                    state_d    = WR_HOST;
                    host_ack_d = 1'b1;
                    if (host_allow) begin
                        reg_we_d    = 1'b1;
                        reg_addr_d  = host_addr;
                        reg_wdata_d = host_wdata;
                    end else begin
                        host_err_d = 1'b1;
                    end
                end else if (core_req) begin
                    state_d     = WR_CORE;
                    core_gnt_d  = 1'b1;
                    reg_we_d    = 1'b1;
                    reg_addr_d  = core_addr;
                    reg_wdata_d = core_wdata;
                end
            end
            WR_HOST, WR_CORE: state_d = DONE;
            DONE:             state_d = IDLE;
            default:          state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            host_ack_q  <= 1'b0;
            host_err_q  <= 1'b0;
            core_gnt_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_we_q    <= reg_we_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            host_ack_q  <= host_ack_d;
            host_err_q  <= host_err_d;
            core_gnt_q  <= core_gnt_d;
        end
    end

    assign reg_we    = reg_we_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign host_ack  = host_ack_q;
    assign host_err  = host_err_q;
    assign core_gnt  = core_gnt_q;

endmodule
